demux14_stream: RTL and testbench

- 1-to-4 demultiplexer for a valid/ready stream; the write-side counterpart of the 4:1 key-select mux.
- One input word carries a 2-bit destination key and is routed to exactly one of four output channels.
- Each output channel has a one-entry holding register, so input and output handshakes are decoupled.
- Each channel also keeps a wrap-around delivery counter for bring-up and debug on the npc board.

---
 rtl/demux14_stream_pkg.sv | 20 ++
 rtl/demux_slot.sv | 86 ++++++++
 rtl/demux14_stream.sv | 57 +++++
 tb/tb_demux14_stream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/demux14_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux14_stream_pkg;

    localparam int NR_CH   = 4;
    localparam int KEY_LEN = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // One-hot channel select for a destination key.
    function automatic logic [NR_CH-1:0] key_decode(input logic [KEY_LEN-1:0] key);
        logic [NR_CH-1:0] sel;
        sel = {NR_CH{1'b0}};
        sel[key] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry holding register, EMPTY/FULL FSM and
// a wrap-around count of words accepted into this channel.
module demux_slot
    import demux14_stream_pkg::*;
#(
    parameter int DATA_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_LEN-1:0] din,
    input  logic                ready_out,
    output logic                valid,
    output logic [DATA_LEN-1:0] dout,
    output logic [CNT_W-1:0]    cnt
);

    slot_state_t         state_r;
    slot_state_t         state_nxt_s;
    logic [DATA_LEN-1:0] data_r;
    logic [CNT_W-1:0]    cnt_r;

    // Slot state register; reset discards any buffered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a load always leaves the slot FULL (covers drain+load),
    // a drain without a load empties it, otherwise hold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load) begin
                    state_nxt_s = SLOT_FULL;
                end else begin
                    state_nxt_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_nxt_s = SLOT_FULL;
                end else if (ready_out) begin
                    state_nxt_s = SLOT_EMPTY;
                end else begin
                    state_nxt_s = SLOT_FULL;
                end
            end
            default: begin
                state_nxt_s = SLOT_EMPTY;
            end
        endcase
    end

    // Data register: captures on load, keeps the last word after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DATA_LEN{1'b0}};
        end else if (load) begin
            data_r <= din;
        end else begin
            data_r <= data_r;
        end
    end

    // Delivery counter: one step per accepted word, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign valid = (state_r == SLOT_FULL);
    assign dout  = data_r;
    assign cnt   = cnt_r;

endmodule

// File: rtl/demux14_stream.sv
// 1-to-4 valid/ready demultiplexer: the input word is steered by its key
// into one of four single-entry channel slots.
module demux14_stream
    import demux14_stream_pkg::*;
#(
    parameter int DATA_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KEY_LEN-1:0]        in_key,
    input  logic [DATA_LEN-1:0]       in_data,
    output logic [NR_CH-1:0]          out_valid,
    input  logic [NR_CH-1:0]          out_ready,
    output logic [NR_CH*DATA_LEN-1:0] out_data,
    output logic [NR_CH*CNT_W-1:0]    out_cnt
);

    logic [NR_CH-1:0] sel_s;
    logic [NR_CH-1:0] load_s;
    logic [NR_CH-1:0] valid_s;
    logic             in_ready_s;

    // Key decode and ready mux: the addressed slot can take a word when it
    // is empty or is being drained this cycle; in_valid does not feed ready.
    always_comb begin
        sel_s      = key_decode(in_key);
        in_ready_s = ~valid_s[in_key] | out_ready[in_key];
        if (in_valid && in_ready_s) begin
            load_s = sel_s;
        end else begin
            load_s = {NR_CH{1'b0}};
        end
    end

    for (genvar g = 0; g < NR_CH; g++) begin : g_slot
        demux_slot #(
            .DATA_LEN (DATA_LEN),
            .CNT_W    (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_s[g]),
            .din       (in_data),
            .ready_out (out_ready[g]),
            .valid     (valid_s[g]),
            .dout      (out_data[DATA_LEN*g +: DATA_LEN]),
            .cnt       (out_cnt[CNT_W*g +: CNT_W])
        );
    end

    assign out_valid = valid_s;
    assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_demux14_stream.sv
// Scoreboard bench for demux14_stream: per-channel expected-word queues and
// accept counters, fed by the stimulus and drained by an independent monitor.
module tb_demux14_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_key;
    logic [1:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [31:0] out_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] exp_q [4][$];
    logic [7:0] cnt_model [4];
    logic       mon_en = 1'b0;

    demux14_stream #(.DATA_LEN(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            cnt_model[k] = 8'd0;
        end
    endtask

    // Monitor: compares every channel each cycle, pops words the consumer takes.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("valid%0d", k), {31'd0, out_valid[k]}, {31'd0, exp_q[k].size() != 0});
                chk($sformatf("cnt%0d", k), {24'd0, out_cnt[8*k +: 8]}, {24'd0, cnt_model[k]});
                if (exp_q[k].size() != 0) begin
                    chk($sformatf("data%0d", k), {30'd0, out_data[2*k +: 2]}, {30'd0, exp_q[k][0]});
                    if (out_ready[k]) begin
                        void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the model decides acceptance and records it.
    task automatic step(input logic v, input logic [1:0] k, input logic [1:0] d,
                        input logic [3:0] r, output logic acc);
        logic exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_key    = k;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        #1;
        exp_rdy = (exp_q[k].size() == 0) || r[k];
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        if (acc) begin
            exp_q[k].push_back(d);
            cnt_model[k] = cnt_model[k] + 8'd1;
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [1:0] d, input logic [3:0] r);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            step(1'b1, k, d, r, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: key %0d not accepted after %0d cycles", k, tries);
        end
    endtask

    task automatic idle(input logic [3:0] r);
        logic acc;
        step(1'b0, 2'd0, 2'd0, r, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_cnt", out_cnt, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        clear_model();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        logic       acc;
        logic       pv;
        logic [1:0] pk;
        logic [1:0] pd;
        logic [3:0] r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_key    = 2'd0;
        in_data   = 2'd0;
        out_ready = 4'b0000;
        clear_model();
        #3;
        chk("init_valid", {28'd0, out_valid}, 32'd0);
        chk("init_cnt", out_cnt, 32'd0);
        chk("init_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic routing, one word per channel on consecutive cycles.
        send(2'd0, 2'b11, 4'b1111);
        send(2'd1, 2'b10, 4'b1111);
        send(2'd2, 2'b01, 4'b1111);
        send(2'd3, 2'b00, 4'b1111);
        idle(4'b1111);
        idle(4'b1111);

        // Backpressure on channel 1, with channel 3 proving isolation.
        send(2'd1, 2'b01, 4'b1101);
        send(2'd3, 2'b11, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd1, 2'b10, 4'b1101, acc);
            chk("bp_reject", {31'd0, acc}, 32'd0);
        end
        send(2'd1, 2'b10, 4'b1111);
        idle(4'b1111);

        // Drain and load channel 0 in the same cycle.
        send(2'd0, 2'b01, 4'b1111);
        step(1'b1, 2'd0, 2'b10, 4'b1111, acc);
        chk("drain_load_acc", {31'd0, acc}, 32'd1);
        idle(4'b1111);

        // Asynchronous reset while slot 2 holds a word.
        send(2'd2, 2'b11, 4'b1011);
        idle(4'b1011);
        do_reset();
        idle(4'b1011);
        idle(4'b1011);

        // Counter wrap on channel 2.
        for (int i = 0; i < 256; i++) begin
            send(2'd2, 2'(i), 4'b1111);
        end
        idle(4'b1111);
        #2;
        chk("cnt_wrap0", {24'd0, out_cnt[23:16]}, 32'd0);
        send(2'd2, 2'b01, 4'b1111);
        idle(4'b1111);
        #2;
        chk("cnt_wrap1", {24'd0, out_cnt[23:16]}, 32'd1);
        chk("cnt_others", {out_cnt[31:24], 8'd0, out_cnt[15:0]}, 32'd0);

        // Randomized traffic; a held word keeps key and data stable.
        pv = 1'b0;
        pk = 2'd0;
        pd = 2'd0;
        for (int i = 0; i < 2000; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pk = 2'($urandom);
                pd = 2'($urandom);
            end
            r = 4'($urandom);
            step(pv, pk, pd, r, acc);
            if (acc) begin
                pv = 1'b0;
            end
        end
        idle(4'b1111);
        idle(4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
